sev_seg_scanner: RTL and testbench
==================================

// Module: sev_seg_scanner
// PURPOSE
//  Parametrised, time-multiplexed N-digit 7-segment display scanner, successor to the fixed 8-digit driver.
//  Adds: refresh prescaler, tear-free double-buffered update, per-digit blank/dp, leading-zero
//  suppression, PWM brightness. Sits between core logic (hex data producer) and board anode/segment pins.
// PARAMETERS
//  NUM_DIGITS   8   digits scanned, legal 1..16
//  REFRESH_LOG2 14  slot length per digit = 2**REFRESH_LOG2 clk cycles; must be > DIM_BITS
//  DIM_BITS     3   brightness control width
//  BLINK_FRAMES 32  frames per blink half-period (used only with SEVSEG_BLINK_EN)
// PORTS
//  clk          in   1             system clock
//  reset        in   1             asynchronous, active-high reset
//  data_in      in   4*NUM_DIGITS  hex nibbles, digit i = data_in[4i+3:4i], digit 0 rightmost
//  dp_in        in   NUM_DIGITS    1 = decimal point lit for digit i
//  blank_in     in   NUM_DIGITS    1 = digit i forced dark
//  update       in   1             strobe: capture data_in/dp_in/blank_in into shadow
//  lz_suppress  in   1             1 = blank leading zero digits
//  brightness   in   DIM_BITS      duty = (brightness+1)/2**DIM_BITS
//  an           out  NUM_DIGITS    anodes, active low
//  seg          out  7             segments {g,f,e,d,c,b,a}, active low
//  dp           out  1             decimal point, active low
//  frame_tick   out  1             1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): an=all 1, seg=7'h7F, dp=1, frame_tick=0, prescaler=0,
//    digit_sel=0, shadow/display regs=0, pending=0. Scan restarts at digit 0 on release.
//  - Prescaler free-runs 0..2**REFRESH_LOG2-1; at terminal count digit_sel increments, wrapping
//    NUM_DIGITS-1 -> 0; that wrap cycle is the frame boundary, frame_tick=1 on the following cycle.
//  - update=1: shadow <= inputs, pending <= 1. At frame boundary with pending: display <= shadow,
//    pending <= 0. update coincident with boundary: display loads inputs directly, pending=0.
//    Successive updates within one frame: last one wins. Display never changes mid-frame.
//  - Decode: hex 0-F all shown (F = 7'b0001110, A = 7'b0001000, etc.); no code maps to blank.
//  - Digit i dark (an[i]=1, seg=7'h7F, dp=1) if blank_in[i], or lz_suppress and i>0 and all display
//    nibbles i..NUM_DIGITS-1 are 0 (digit 0 never suppressed).
//  - PWM: selected anode low only while prescaler[REFRESH_LOG2-1 -: DIM_BITS] <= brightness;
//    brightness all-1s = 100% on. Outside window an=all 1, seg=7'h7F, dp=1.
//  - an/seg/dp registered: 1-cycle latency from digit_sel/prescaler state; at most one an bit low.
//  - brightness, lz_suppress sampled live (not buffered).
// CONFIGURATION
//  SEVSEG_BLINK_EN defined: adds port blink_in [NUM_DIGITS-1:0] and a frame counter; blink phase
//  toggles every BLINK_FRAMES frame boundaries (starts "on" after reset); digits with blink_in[i]=1
//  are dark during "off" phase. blink_in is double-buffered with the other inputs.
//  Not defined: no blink_in port, no counter, digits never blink.
// STRUCTURE
//  Package sev_seg_pkg: SEG_* active-low glyph constants for 0-F, SEG_BLANK=7'h7F, localparam helper
//  for digit_sel width ($clog2(NUM_DIGITS), min 1).
//  One sub-module: sev_seg_hex_decode (combinational nibble -> seg using package constants).
// TESTING (NUM_DIGITS=4, REFRESH_LOG2=4, DIM_BITS=2)
//  1 reset held mid-scan -> an=4'hF, seg=7'h7F, dp=1 immediately; release -> digit0 slot first, shows 0.
//  2 update 16'h12AF, brightness=3 -> after frame_tick digits0..3 seg=0001110,0001000,0100100,1111001,
//    each an bit low 16 cycles.
//  3 update 16'h5555 mid-frame -> remaining slots keep old value; all digits show 5 from next frame.
//  4 lz_suppress=1, data 16'h0030 -> an[3],an[2] stay 1; digit1=3, digit0=0; data 0 -> only digit0 lit.
//  5 brightness=0 -> anode low 4 of 16 cycles per slot; dp_in=4'b0100 -> dp=0 only in digit2 window.
//  6 SEVSEG_BLINK_EN, BLINK_FRAMES=2, blink_in=4'b0001 -> digit0 dark 2 frames, lit 2 frames, repeat.

Source files
------------

// File: rtl/sev_seg_pkg.sv
// Shared glyph table and sizing helper for the seven-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active low.
package sev_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Counter width for n states; never below one bit so a single digit still has a select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sev_seg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
module sev_seg_hex_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/sev_seg_scanner.sv
// Time-multiplexed N-digit seven-segment scanner with frame-aligned double buffering and PWM dimming.
// Define SEVSEG_BLINK_EN to add the blink_in port and per-digit blinking.
module sev_seg_scanner
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_LOG2 = 14,
    parameter int DIM_BITS     = 3,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    update,
    input  logic                    lz_suppress,
`ifdef SEVSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int SEL_W = sel_width(NUM_DIGITS);

    logic [REFRESH_LOG2-1:0] prescaler;
    logic [SEL_W-1:0]        digit_sel;
    logic                    slot_end;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] shadow_data, disp_data;
    logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank, disp_blank;
    logic                    pending;

    logic [NUM_DIGITS-1:0]   blink_dark;
    logic [NUM_DIGITS-1:0]   dark_mask;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic                    pwm_on;

    assign slot_end  = &prescaler;
    assign frame_end = slot_end && (digit_sel == SEL_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler  <= '0;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            frame_tick <= frame_end;
            if (slot_end)
                digit_sel <= frame_end ? '0 : digit_sel + 1'b1;
        end
    end

    // An update landing on the frame boundary bypasses the shadow so it is not delayed a whole frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            disp_data    <= '0;
            disp_dp      <= '0;
            disp_blank   <= '0;
            pending      <= 1'b0;
        end else begin
            if (update) begin
                shadow_data  <= data_in;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_in;
            end
            if (frame_end) begin
                pending <= 1'b0;
                if (update) begin
                    disp_data  <= data_in;
                    disp_dp    <= dp_in;
                    disp_blank <= blank_in;
                end else if (pending) begin
                    disp_data  <= shadow_data;
                    disp_dp    <= shadow_dp;
                    disp_blank <= shadow_blank;
                end
            end else if (update) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int BLINK_W = sel_width(BLINK_FRAMES);

    logic [NUM_DIGITS-1:0] shadow_blink, disp_blink;
    logic [BLINK_W-1:0]    frame_cnt;
    logic                  blink_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_blink <= '0;
            disp_blink   <= '0;
            frame_cnt    <= '0;
            blink_on     <= 1'b1;
        end else begin
            if (update)
                shadow_blink <= blink_in;
            if (frame_end) begin
                if (update)
                    disp_blink <= blink_in;
                else if (pending)
                    disp_blink <= shadow_blink;
                if (frame_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign blink_dark = blink_on ? '0 : disp_blink;
`else
    logic unused_blink_cfg;

    assign unused_blink_cfg = (BLINK_FRAMES > 0);
    assign blink_dark       = '0;
`endif

    // Scan from the top digit down so zero_run says whether every nibble at or above i is zero.
    always_comb begin
        dark_mask = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (disp_data[4*i +: 4] == 4'h0);
            dark_mask[i] = disp_blank[i] | blink_dark[i] | (lz_suppress & zero_run & (i != 0));
        end
    end

    assign cur_nib = disp_data[4*digit_sel +: 4];
    assign pwm_on  = (prescaler[REFRESH_LOG2-1 -: DIM_BITS] <= brightness);

    sev_seg_hex_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (pwm_on && !dark_mask[digit_sel]) begin
            an  <= ~(NUM_DIGITS'(1) << digit_sel);
            seg <= dec_seg;
            dp  <= ~disp_dp[digit_sel];
        end else begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sev_seg_scanner.sv
// Scoreboard bench for sev_seg_scanner with 4 digits and 16-cycle slots.
// Blink checks are compiled in when SEVSEG_BLINK_EN is defined.
module tb_sev_seg_scanner;

    localparam int ND    = 4;
    localparam int SLOT  = 16;
    localparam int FRAME = ND * SLOT;
    localparam int BF    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        update;
    logic        lz_suppress;
    logic [1:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
`ifdef SEVSEG_BLINK_EN
    logic [3:0]  blink_in;
`endif

    typedef struct {
        int         digit;
        logic [6:0] seg;
        logic       dp;
        int         on_cycles;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         tick_count;
    logic [3:0] an_cap  [FRAME];
    logic [6:0] seg_cap [FRAME];
    logic       dp_cap  [FRAME];
    logic       ft_cap  [FRAME];

    sev_seg_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_LOG2 (4),
        .DIM_BITS     (2),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .update      (update),
        .lz_suppress (lz_suppress),
`ifdef SEVSEG_BLINK_EN
        .blink_in    (blink_in),
`endif
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset)
            tick_count <= 0;
        else if (frame_tick)
            tick_count <= tick_count + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic push_digit(input int d, input logic [3:0] nib, input logic dpv, input int on);
        exp_t e;
        e.digit = d; e.seg = glyph(nib); e.dp = dpv; e.on_cycles = on;
        sb.push_back(e);
    endtask

    task automatic do_update(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
        @(negedge clk);
        data_in = d; dp_in = dpv; blank_in = bl; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (frame_tick !== 1'b1) begin
            bad++;
            $display("[TB] FAIL frame_wait: frame_tick=%b, required 1 within 300 cycles", frame_tick);
        end
    endtask

    // Called on the negedge where frame_tick is high; records one full frame of outputs.
    task automatic capture_frame(input int upd_at, input logic [15:0] upd_data);
        for (int k = 0; k < FRAME; k++) begin
            if (k == upd_at) begin
                data_in = upd_data;
                update  = 1'b1;
            end
            @(negedge clk);
            update     = 1'b0;
            an_cap[k]  = an;
            seg_cap[k] = seg;
            dp_cap[k]  = dp;
            ft_cap[k]  = frame_tick;
        end
    endtask

    task automatic digit_stats(input int d, output int on_cnt, output logic [6:0] s,
                               output logic dpo, output int viol);
        logic [3:0] pat;
        logic       seen_off;
        int         k;
        pat = ~(4'b0001 << d);
        on_cnt = 0; viol = 0; s = 7'h7F; dpo = 1'b1; seen_off = 1'b0;
        for (int j = 0; j < SLOT; j++) begin
            k = d * SLOT + j;
            if (an_cap[k] === pat) begin
                if (seen_off) viol++;
                if (on_cnt == 0) begin
                    s = seg_cap[k]; dpo = dp_cap[k];
                end else if (seg_cap[k] !== s || dp_cap[k] !== dpo) begin
                    viol++;
                end
                on_cnt++;
            end else begin
                seen_off = 1'b1;
                if (an_cap[k] !== 4'hF || seg_cap[k] !== 7'h7F || dp_cap[k] !== 1'b1) viol++;
            end
        end
    endtask

    task automatic test_reset();
        do_update(16'h12AF, 4'h0, 4'h0);
        wait_frame();
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if (an !== 4'hF) begin bad++; $display("[TB] FAIL reset_an: got %h, want f", an); end
        total++; if (seg !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg: got %h, want 7f", seg); end
        total++; if (dp !== 1'b1) begin bad++; $display("[TB] FAIL reset_dp: got %b, want 1", dp); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick: got %b, want 0", frame_tick); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (an !== 4'b1110) begin bad++; $display("[TB] FAIL release_an: got %b, want 1110", an); end
        total++; if (seg !== glyph(4'h0)) begin bad++; $display("[TB] FAIL release_seg: got %h, want %h", seg, glyph(4'h0)); end
        total++; if (dp !== 1'b1) begin bad++; $display("[TB] FAIL release_dp: got %b, want 1", dp); end
    endtask

    task automatic test_update();
        exp_t e; int on_cnt, viol, ticks; logic [6:0] s; logic dpo;
        brightness = 2'd3;
        do_update(16'h12AF, 4'h0, 4'h0);
        wait_frame();
        for (int d = 0; d < ND; d++) push_digit(d, data_in[4*d +: 4], 1'b1, SLOT);
        capture_frame(-1, 16'h0);
        ticks = 0;
        for (int k = 0; k < FRAME; k++) if (ft_cap[k] === 1'b1) ticks++;
        total++; if (ticks !== 1) begin bad++; $display("[TB] FAIL tick_count: got %0d pulses, want 1", ticks); end
        total++; if (ft_cap[FRAME-1] !== 1'b1) begin bad++; $display("[TB] FAIL tick_pos: got %b at frame end, want 1", ft_cap[FRAME-1]); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            digit_stats(e.digit, on_cnt, s, dpo, viol);
            total++; if (on_cnt !== e.on_cycles) begin bad++; $display("[TB] FAIL upd_on d%0d: got %0d, want %0d", e.digit, on_cnt, e.on_cycles); end
            total++; if (viol !== 0) begin bad++; $display("[TB] FAIL upd_viol d%0d: got %0d, want 0", e.digit, viol); end
            total++; if (s !== e.seg) begin bad++; $display("[TB] FAIL upd_seg d%0d: got %b, want %b", e.digit, s, e.seg); end
            total++; if (dpo !== e.dp) begin bad++; $display("[TB] FAIL upd_dp d%0d: got %b, want %b", e.digit, dpo, e.dp); end
        end
    endtask

    task automatic test_midframe();
        exp_t e; int on_cnt, viol; logic [6:0] s; logic dpo;
        logic [15:0] vals [2];
        vals[0] = 16'h12AF; vals[1] = 16'h5555;
        for (int f = 0; f < 2; f++) begin
            wait_frame();
            for (int d = 0; d < ND; d++) push_digit(d, vals[f][4*d +: 4], 1'b1, SLOT);
            capture_frame(f == 0 ? 20 : -1, 16'h5555);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                digit_stats(e.digit, on_cnt, s, dpo, viol);
                total++; if (on_cnt !== e.on_cycles) begin bad++; $display("[TB] FAIL mid_on f%0d d%0d: got %0d, want %0d", f, e.digit, on_cnt, e.on_cycles); end
                total++; if (viol !== 0) begin bad++; $display("[TB] FAIL mid_viol f%0d d%0d: got %0d, want 0", f, e.digit, viol); end
                total++; if (s !== e.seg) begin bad++; $display("[TB] FAIL mid_seg f%0d d%0d: got %b, want %b", f, e.digit, s, e.seg); end
            end
        end
    endtask

    task automatic test_lz_suppress();
        exp_t e; int on_cnt, viol; logic [6:0] s; logic dpo;
        lz_suppress = 1'b1;
        for (int p = 0; p < 2; p++) begin
            do_update(p == 0 ? 16'h0030 : 16'h0000, 4'h0, 4'h0);
            wait_frame();
            push_digit(0, 4'h0, 1'b1, SLOT);
            push_digit(1, p == 0 ? 4'h3 : 4'h0, 1'b1, p == 0 ? SLOT : 0);
            push_digit(2, 4'h0, 1'b1, 0);
            push_digit(3, 4'h0, 1'b1, 0);
            capture_frame(-1, 16'h0);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                digit_stats(e.digit, on_cnt, s, dpo, viol);
                total++; if (on_cnt !== e.on_cycles) begin bad++; $display("[TB] FAIL lz_on p%0d d%0d: got %0d, want %0d", p, e.digit, on_cnt, e.on_cycles); end
                total++; if (viol !== 0) begin bad++; $display("[TB] FAIL lz_viol p%0d d%0d: got %0d, want 0", p, e.digit, viol); end
                if (e.on_cycles > 0) begin
                    total++; if (s !== e.seg) begin bad++; $display("[TB] FAIL lz_seg p%0d d%0d: got %b, want %b", p, e.digit, s, e.seg); end
                end
            end
        end
        lz_suppress = 1'b0;
    endtask

    task automatic test_pwm_dp_blank();
        exp_t e; int on_cnt, viol; logic [6:0] s; logic dpo;
        brightness = 2'd0;
        do_update(16'h8421, 4'b1100, 4'b1000);
        wait_frame();
        for (int f = 0; f < 2; f++) begin
            if (f == 1) brightness = 2'd2;
            for (int d = 0; d < 3; d++) push_digit(d, data_in[4*d +: 4], d != 2, f == 0 ? 4 : 12);
            push_digit(3, 4'h8, 1'b1, 0);
            capture_frame(-1, 16'h0);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                digit_stats(e.digit, on_cnt, s, dpo, viol);
                total++; if (on_cnt !== e.on_cycles) begin bad++; $display("[TB] FAIL pwm_on f%0d d%0d: got %0d, want %0d", f, e.digit, on_cnt, e.on_cycles); end
                total++; if (viol !== 0) begin bad++; $display("[TB] FAIL pwm_viol f%0d d%0d: got %0d, want 0", f, e.digit, viol); end
                if (e.on_cycles > 0) begin
                    total++; if (s !== e.seg) begin bad++; $display("[TB] FAIL pwm_seg f%0d d%0d: got %b, want %b", f, e.digit, s, e.seg); end
                    total++; if (dpo !== e.dp) begin bad++; $display("[TB] FAIL pwm_dp f%0d d%0d: got %b, want %b", f, e.digit, dpo, e.dp); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int on_cnt, viol; logic [6:0] s; logic dpo;
        brightness = 2'd3;
        wait_frame();
        repeat (5) @(negedge clk);
        do_update(16'h1111, 4'h0, 4'h0);
        do_update(16'hCDE9, 4'h0, 4'h0);
        wait_frame();
        for (int d = 0; d < ND; d++) push_digit(d, data_in[4*d +: 4], 1'b1, SLOT);
        capture_frame(-1, 16'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            digit_stats(e.digit, on_cnt, s, dpo, viol);
            total++; if (on_cnt !== e.on_cycles) begin bad++; $display("[TB] FAIL b2b_on d%0d: got %0d, want %0d", e.digit, on_cnt, e.on_cycles); end
            total++; if (s !== e.seg) begin bad++; $display("[TB] FAIL b2b_seg d%0d: got %b, want %b", e.digit, s, e.seg); end
        end
    endtask

`ifdef SEVSEG_BLINK_EN
    task automatic test_blink();
        exp_t e; int on_cnt, viol, n; logic [6:0] s; logic dpo;
        blink_in = 4'b0001;
        do_update(16'h4321, 4'h0, 4'h0);
        wait_frame();
        for (int f = 0; f < 4; f++) begin
            n = tick_count + 1;
            push_digit(0, 4'h1, 1'b1, ((n / BF) % 2 == 0) ? SLOT : 0);
            for (int d = 1; d < ND; d++) push_digit(d, data_in[4*d +: 4], 1'b1, SLOT);
            capture_frame(-1, 16'h0);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                digit_stats(e.digit, on_cnt, s, dpo, viol);
                total++; if (on_cnt !== e.on_cycles) begin bad++; $display("[TB] FAIL blink_on frame%0d d%0d: got %0d, want %0d", n, e.digit, on_cnt, e.on_cycles); end
                total++; if (viol !== 0) begin bad++; $display("[TB] FAIL blink_viol frame%0d d%0d: got %0d, want 0", n, e.digit, viol); end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1; data_in = '0; dp_in = '0; blank_in = '0; update = 1'b0;
        lz_suppress = 1'b0; brightness = 2'd3;
`ifdef SEVSEG_BLINK_EN
        blink_in = '0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        $display("[TB] starting sev_seg_scanner checks");
        test_reset();
        test_update();
        test_midframe();
        test_lz_suppress();
        test_pwm_dp_blank();
        test_back_to_back();
`ifdef SEVSEG_BLINK_EN
        test_blink();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
